// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I fetch constants and the fetch buffer entry type
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic mis;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush and full/empty flags
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter type T = logic
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     wdata_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic do_push, do_pop;
  assign empty_o = wp_q == rp_q;
  assign full_o = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign rdata_o = mem_q[rp_q[AW-1:0]];
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wp_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage owning the PC and buffering {pc, instr} for decode
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_enable,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic            dec_misaligned,
  output logic [XLEN-1:0] fetch_count
);
  logic [XLEN-1:0] pc_q, pc_d, cnt_q, cnt_d, last_pc_q;
  logic mis_q, mis_d, full, empty, push, pop;
  fetch_entry_t head, entry;
  assign pop = dec_valid & dec_ready;
  assign push = fetch_enable & !redirect_valid & (!full | pop);
  assign entry = '{pc: pc_q, instr: imem_instr, mis: mis_q};
  always_comb begin
    pc_d = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : push ? pc_q + PC_STEP : pc_q;
    mis_d = redirect_valid ? |redirect_pc[1:0] : push ? 1'b0 : mis_q;
    cnt_d = push ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
      mis_q <= 1'b0;
      cnt_q <= '0;
      last_pc_q <= '0;
    end else begin
      pc_q <= pc_d;
      mis_q <= mis_d;
      cnt_q <= cnt_d;
      if (!empty) last_pc_q <= head.pc;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .flush_i(redirect_valid),
    .push_i(push),
    .pop_i(pop),
    .wdata_i(entry),
    .rdata_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  assign imem_addr = pc_q;
  assign dec_valid = !empty;
  assign dec_instr = empty ? INSTR_NOP : head.instr;
  assign dec_pc = empty ? last_pc_q : head.pc;
  assign dec_misaligned = !empty & head.mis;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch_unit bench against a queue-based reference model
module tb_fetch_unit;
  import rv32i_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0, reset_n = 0, fetch_enable = 0, redirect_valid = 0, dec_ready = 0;
  logic [31:0] redirect_pc = 0, imem_addr, imem_instr, dec_instr, dec_pc, fetch_count;
  logic dec_valid, dec_misaligned;
  logic [31:0] mem [64];
  int checks = 0, failures = 0;
  fetch_entry_t q[$];
  logic [31:0] m_pc, m_cnt, m_last;
  logic m_mis;
  always #5 clk = ~clk;
  assign imem_instr = mem[imem_addr[7:2]];
  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_enable(fetch_enable),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_misaligned(dec_misaligned), .fetch_count(fetch_count)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset;
    q.delete();
    m_pc = 32'h0;
    m_cnt = 0;
    m_last = 0;
    m_mis = 0;
  endtask
  task automatic step(bit en, bit rv, logic [31:0] rpc, bit rdy);
    fetch_entry_t h;
    bit valid, pop, push;
    valid = q.size() > 0;
    h = valid ? q[0] : '0;
    if (valid) m_last = h.pc;
    check("dec_valid", {31'b0, dec_valid}, {31'b0, valid});
    check("dec_instr", dec_instr, valid ? h.instr : INSTR_NOP);
    check("dec_pc", dec_pc, m_last);
    check("dec_misaligned", {31'b0, dec_misaligned}, {31'b0, valid & h.mis});
    check("imem_addr", imem_addr, m_pc);
    check("fetch_count", fetch_count, m_cnt);
    fetch_enable = en;
    redirect_valid = rv;
    redirect_pc = rpc;
    dec_ready = rdy;
    pop = valid && rdy;
    if (rv) begin
      q.delete();
      m_pc = rpc & ~32'h3;
      m_mis = rpc[1:0] != 2'b00;
    end else begin
      push = en && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: m_pc, instr: mem[m_pc[7:2]], mis: m_mis});
        m_pc = m_pc + 32'd4;
        m_mis = 0;
        m_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rand_step;
    step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 2) != 0);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (8) step(1, 0, 0, 1);
    repeat (5) step(1, 0, 0, 0);
    repeat (4) step(1, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 32'h40, 0);
    repeat (4) step(1, 0, 0, 1);
    step(1, 1, 32'h42, 1);
    repeat (4) step(1, 0, 0, 1);
    step(1, 1, 32'hFFFF_FFF8, 0);
    repeat (4) step(1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    step(0, 1, 32'h81, 1);
    repeat (3) step(1, 0, 0, 1);
    repeat (1500) rand_step();
    repeat (2) step(1, 0, 0, 0);
    #2 reset_n = 0;
    #1;
    check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_fetch_count", fetch_count, 32'd0);
    check("rst_dec_instr", dec_instr, INSTR_NOP);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    repeat (200) rand_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
